// File: rtl/booth_mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// booth_mult_seq_pkg
//
// Shared definitions for the sequential radix-4 Booth multiplier:
//   DEFAULT_WIDTH  - default operand width used by booth_mult_seq
//   booth_code_t   - {neg, mag[1:0]} partial-product selector produced by the
//                    encoder (ZERO, PM, P2M, NM, N2M)
//   state_t        - FSM state encoding (IDLE, CALC)
//   booth_decode() - maps a 3-bit Booth window onto a booth_code_t
// -----------------------------------------------------------------------------
package booth_mult_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Bit 2 is the negate flag, bits 1:0 the magnitude (0, 1 or 2 times M).
    typedef enum logic [2:0] {
        ZERO = 3'b000,
        PM   = 3'b001,
        P2M  = 3'b010,
        NM   = 3'b101,
        N2M  = 3'b110
    } booth_code_t;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Window {q[2i+1], q[2i], q[2i-1]} has weight -2*q[2i+1] + q[2i] + q[2i-1].
    function automatic booth_code_t booth_decode(input logic [2:0] window);
        booth_code_t code;
        case (window)
            3'b001, 3'b010: code = PM;
            3'b011:         code = P2M;
            3'b100:         code = N2M;
            3'b101, 3'b110: code = NM;
            default:        code = ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/booth_mult_seq_encoder.sv
// -----------------------------------------------------------------------------
// booth_encoder
//
// Purely combinational radix-4 Booth window decoder.
// Ports:
//   window - input  [2:0] : {q[2i+1], q[2i], q[2i-1]}
//   code   - output booth_code_t : {neg, mag[1:0]} selector for the partial
//                                  product (ZERO, PM, P2M, NM, N2M)
// -----------------------------------------------------------------------------
module booth_encoder
    import booth_mult_seq_pkg::*;
(
    input  logic [2:0]  window,
    output booth_code_t code
);

    // The decode table lives in the package so every user sees the same mapping.
    always_comb begin
        code = booth_decode(window);
    end

endmodule

// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
//
// Sequential signed multiplier using radix-4 Booth recoding. One Booth digit
// is retired per clock, so a WIDTH x WIDTH multiply takes WIDTH/2 cycles after
// the start-accept edge.
//
// Parameters:
//   WIDTH        - operand width; even and >= 4 (default DEFAULT_WIDTH = 8)
// Ports:
//   clk          - input            : clock, rising-edge active
//   rst_n        - input            : asynchronous active-low reset
//   start        - input            : begin a multiply (honoured only in IDLE)
//   multiplicand - input  [WIDTH-1:0]   : signed M
//   multiplier   - input  [WIDTH-1:0]   : signed Q
//   busy         - output           : high while in CALC
//   done         - output           : one-cycle completion pulse
//   product      - output [2*WIDTH-1:0] : signed M*Q, held until next completion
//
// Build option:
//   BOOTH_EARLY_TERM_EN - when defined, the operation finishes at the first step
//                         after which every remaining Booth digit is zero
//                         (latency 1..WIDTH/2). When undefined the latency is
//                         always WIDTH/2. Products are identical either way.
// -----------------------------------------------------------------------------
module booth_mult_seq
    import booth_mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int STEPS = WIDTH / 2;
    localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [IW-1:0] LAST_STEP = IW'(STEPS - 1);

    state_t               state;
    logic [WIDTH-1:0]     m_reg;
    logic [WIDTH:0]       q_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [IW-1:0]        step;

    booth_code_t          code;
    logic [WIDTH+1:0]     m_ext;
    logic [WIDTH+1:0]     pp;
    logic [2*WIDTH-1:0]   pp_wide;
    logic [2*WIDTH-1:0]   acc_next;
    logic [IW:0]          shamt;
    logic                 early_done;
    logic                 last_step;

    // q_reg holds {Q,0} shifted right arithmetically by two per step, so the
    // current Booth window is always its three LSBs.
    booth_encoder u_encoder (
        .window (q_reg[2:0]),
        .code   (code)
    );

    // Build the partial product for this step and add it, weighted by 4^step,
    // into the accumulator. WIDTH+2 bits are enough to hold +/-2M, including
    // -2 * -2^(WIDTH-1).
    always_comb begin
        m_ext = {{2{m_reg[WIDTH-1]}}, m_reg};
        case (code[1:0])
            2'b01:   pp = m_ext;
            2'b10:   pp = m_ext << 1;
            default: pp = '0;
        endcase
        if (code[2]) begin
            pp = -pp;
        end
        shamt    = {step, 1'b0};
        pp_wide  = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
        acc_next = acc + (pp_wide << shamt);
    end

    // q_reg[WIDTH:2] are the multiplier bits from the top of the current window
    // upward (with sign fill). If they are uniform, every later window decodes
    // to ZERO and this step may finish the operation.
`ifdef BOOTH_EARLY_TERM_EN
    assign early_done = (q_reg[WIDTH:2] == '0) || (q_reg[WIDTH:2] == '1);
`else
    assign early_done = 1'b0;
`endif

    assign last_step = (step == LAST_STEP) || early_done;

    // Control FSM plus datapath registers. done defaults low every edge so it
    // only pulses on the completing step; because that step also returns to
    // IDLE, a start held high is accepted on the very next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            step    <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= {multiplier, 1'b0};
                        acc   <= '0;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (last_step) begin
                        product <= acc_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        step  <= step + IW'(1);
                        q_reg <= {{2{q_reg[WIDTH]}}, q_reg[WIDTH:2]};
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
//
// Self-checking bench for booth_mult_seq with WIDTH=8. Expected products are
// computed with a plain signed multiply, queued when an operation is launched
// and compared when done pulses. Latency expectations follow the
// BOOTH_EARLY_TERM_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

    localparam int W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [W-1:0]      multiplicand;
    logic [W-1:0]      multiplier;
    logic              busy;
    logic              done;
    logic [2*W-1:0]    product;

    logic [2*W-1:0]    exp_q[$];
    int                assert_count = 0;
    int                fail_count   = 0;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    // Every comparison funnels through here so the counters stay consistent.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference product: both operands sign-extend into the 16-bit context.
    function automatic logic [2*W-1:0] expProd(input logic signed [W-1:0] m,
                                               input logic signed [W-1:0] q);
        logic signed [2*W-1:0] r;
        r = m * q;
        return r;
    endfunction

    // Expected latency: with early termination the operation ends at the
    // first step s whose remaining multiplier bits q[W-1:2s+1] are uniform.
    function automatic int expLat(input logic [W-1:0] q);
        int early;
        early = W / 2;
        for (int s = W / 2 - 1; s >= 0; s--) begin
            logic uniform;
            uniform = 1'b1;
            for (int b = 2 * s + 1; b < W; b++) begin
                if (q[b] !== q[W-1]) uniform = 1'b0;
            end
            if (uniform) early = s + 1;
        end
`ifdef BOOTH_EARLY_TERM_EN
        return early;
`else
        return (early > 0) ? W / 2 : W / 2;
`endif
    endfunction

    // Called just after a rising edge with the DUT idle; launches one multiply
    // and returns just after the accept edge.
    task automatic applyStimulus(input logic [W-1:0] m, input logic [W-1:0] q);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        exp_q.push_back(expProd(m, q));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accept edge until done, checking busy on the way.
    task automatic waitDone(input int exp_lat, input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
            else checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        end
        checkOutput({tag, " latency"}, n, exp_lat);
        if (seen) checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            checkOutput("scoreboard has entry at done", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                checkOutput("product", 32'(product), 32'(e));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        #2;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset product", 32'(product), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no start after reset release", 32'(busy), 32'd0);

        $display("[TB] basic 7 * 3");
        applyStimulus(8'd7, 8'd3);
        checkOutput("busy after accept", 32'(busy), 32'd1);
        waitDone(expLat(8'd3), "7*3");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("product held", 32'(product), 32'd21);

        $display("[TB] boundary operands");
        applyStimulus(8'h80, 8'h80);
        checkOutput("product unchanged on accept", 32'(product), 32'd21);
        waitDone(expLat(8'h80), "-128*-128");
        checkOutput("min*min value", 32'(product), 32'h4000);
        applyStimulus(8'h80, 8'h7F);
        waitDone(expLat(8'h7F), "-128*127");
        checkOutput("min*max value", 32'(product), 32'hC080);

        $display("[TB] start held through CALC");
        multiplicand = 8'd10;
        multiplier   = 8'hFD;
        start        = 1'b1;
        exp_q.push_back(expProd(8'd10, 8'hFD));
        @(posedge clk);
        #1;
        multiplicand = 8'hF7;
        multiplier   = 8'd11;
        waitDone(expLat(8'hFD), "held first");
        exp_q.push_back(expProd(8'hF7, 8'd11));
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("held second accepted", 32'(busy), 32'd1);
        waitDone(expLat(8'd11), "held second");
        checkOutput("held second value", 32'(product), 32'hFF9D);

        $display("[TB] reset during CALC");
        applyStimulus(8'd100, 8'd50);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midcalc reset busy", 32'(busy), 32'd0);
        checkOutput("midcalc reset done", 32'(done), 32'd0);
        checkOutput("midcalc reset product", 32'(product), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle after midcalc reset", 32'(busy), 32'd0);
        applyStimulus(8'd5, 8'hFA);
        waitDone(expLat(8'hFA), "5*-6");
        checkOutput("5*-6 value", 32'(product), 32'hFFE2);

        $display("[TB] early termination candidates");
        applyStimulus(8'd5, 8'd1);
        waitDone(expLat(8'd1), "5*1");
        checkOutput("5*1 value", 32'(product), 32'd5);
        applyStimulus(8'd3, 8'hFF);
        waitDone(expLat(8'hFF), "3*-1");
        checkOutput("3*-1 value", 32'(product), 32'hFFFD);
        applyStimulus(8'h7F, 8'd0);
        waitDone(expLat(8'd0), "127*0");

        $display("[TB] random sweep");
        for (int k = 0; k < 10000; k++) begin
            logic [W-1:0] m;
            logic [W-1:0] q;
            m = W'($urandom);
            q = W'($urandom);
            applyStimulus(m, q);
            waitDone(expLat(q), "sweep");
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
